// File: rtl/fetcher_pkg.sv
// Shared definitions for the instruction fetch stage: opcodes, defaults,
// queue entry layout and the fetch FSM state type.
package fetcher_pkg;

   localparam int          IQ_DEPTH_DEF = 8;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam int INST_W    = 32;
   localparam int PC_W      = 32;
   localparam int PRED_W    = 1;
   localparam int PRED_PC_W = 32;

   typedef enum logic {
      ST_REQ  = 1'b0,
      ST_WAIT = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [INST_W-1:0]    inst;
      logic [PC_W-1:0]      pc;
      logic [PRED_W-1:0]    pred_taken;
      logic [PRED_PC_W-1:0] pred_pc;
   } iq_entry_t;

endpackage

// File: rtl/fetcher_fetch_queue.sv
// In-order instruction queue: circular buffer with a registered head so the
// decoder sees a flop-driven entry; flush empties it in one cycle.
module fetch_queue
   import fetcher_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH_DEF
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       flush,
   input  logic                       push,
   input  iq_entry_t                  push_data,
   input  logic                       pop,
   output iq_entry_t                  head,
   output logic                       head_valid,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);
   localparam logic [AW:0] CNT_ZERO = '0;

   iq_entry_t       mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   rd_inc;
   logic            do_pop;

   assign do_pop = pop && (count != CNT_ZERO);
   assign rd_inc = rd_ptr + AW'(1);

   always_ff @(posedge clk_in) begin
      if (push)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in || flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         head       <= '0;
         head_valid <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_inc;
         if (push && !do_pop)
            count <= count + CNT_ONE;
         else if (!push && do_pop)
            count <= count - CNT_ONE;

         // Head must already hold the next entry when the pop lands, or the
         // incoming push when the queue was (or becomes) empty.
         if (do_pop) begin
            if (count > CNT_ONE) begin
               head       <= mem[rd_inc];
               head_valid <= 1'b1;
            end else if (push) begin
               head       <= push_data;
               head_valid <= 1'b1;
            end else begin
               head_valid <= 1'b0;
            end
         end else if ((count == CNT_ZERO) && push) begin
            head       <= push_data;
            head_valid <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/fetcher.sv
// Instruction fetch stage: PC, REQ/WAIT request FSM toward the Cache, and the
// instruction queue. Static predictor enabled by defining FETCH_PREDICT_EN.
module fetcher
   import fetcher_pkg::*;
#(
   parameter int          IQ_DEPTH = IQ_DEPTH_DEF,
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         rdy_in,
   input  logic         rob_clear,
   input  logic [31:0]  clear_pc,
   output logic         need_inst,
   output logic [31:0]  inst_addr,
   input  logic         inst_handle,
   input  logic         inst_ready,
   input  logic [31:0]  inst_out,
   output logic         iq_valid,
   output logic [31:0]  iq_inst,
   output logic [31:0]  iq_pc,
   output logic         iq_pred_taken,
   output logic [31:0]  iq_pred_pc,
   input  logic         dec_pop,
   output fetch_state_e dbg_state
);

   localparam int CW = $clog2(IQ_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_CNT = CW'(IQ_DEPTH);

   fetch_state_e  state;
   logic [31:0]   pc;
   logic [31:0]   next_pc;
   logic          pred_taken;
   logic [CW-1:0] count;
   logic          active;
   logic          take_hit;
   logic          issue_miss;
   logic          miss_return;
   logic          push;
   logic          pop;
   logic          flush;
   iq_entry_t     push_data;
   iq_entry_t     head;

   // Valid/ready contract with the Cache: a request is accepted in the cycle
   // need_inst && inst_handle; the reply is the cycle inst_ready is seen
   // (same cycle for a hit, a later cycle in WAIT for a miss).
   assign active      = rdy_in && !rst_in && !rob_clear;
   assign need_inst   = active && (state == ST_REQ) && (count < DEPTH_CNT);
   assign take_hit    = need_inst && inst_handle && inst_ready;
   assign issue_miss  = need_inst && inst_handle && !inst_ready;
   assign miss_return = active && (state == ST_WAIT) && inst_ready;
   assign push        = take_hit || miss_return;
   assign pop         = active && dec_pop;
   assign flush       = rdy_in && rob_clear;
   assign inst_addr   = pc;
   assign dbg_state   = state;

`ifdef FETCH_PREDICT_EN
   logic [31:0] j_imm;
   logic [31:0] b_imm;

   always_comb begin
      j_imm = {{11{inst_out[31]}}, inst_out[31], inst_out[19:12], inst_out[20],
               inst_out[30:21], 1'b0};
      b_imm = {{19{inst_out[31]}}, inst_out[31], inst_out[7], inst_out[30:25],
               inst_out[11:8], 1'b0};
      pred_taken = 1'b0;
      next_pc    = pc + 32'd4;
      if (inst_out[6:0] == OPC_JAL) begin
         pred_taken = 1'b1;
         next_pc    = pc + j_imm;
      end else if ((inst_out[6:0] == OPC_BRANCH) && inst_out[31]) begin
         // Backward branches are assumed to be loop-closing, hence taken.
         pred_taken = 1'b1;
         next_pc    = pc + b_imm;
      end
   end
`else
   always_comb begin
      pred_taken = 1'b0;
      next_pc    = pc + 32'd4;
   end
`endif

   always_comb begin
      push_data            = '0;
      push_data.inst       = inst_out;
      push_data.pc         = pc;
      push_data.pred_taken = pred_taken;
      push_data.pred_pc    = next_pc;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         pc    <= RESET_PC;
         state <= ST_REQ;
      end else if (rdy_in) begin
         if (rob_clear) begin
            pc    <= clear_pc;
            state <= ST_REQ;
         end else begin
            case (state)
               ST_REQ: begin
                  if (take_hit)
                     pc <= next_pc;
                  else if (issue_miss)
                     state <= ST_WAIT;
               end
               ST_WAIT: begin
                  if (inst_ready) begin
                     pc    <= next_pc;
                     state <= ST_REQ;
                  end
               end
               default: state <= ST_REQ;
            endcase
         end
      end
   end

   fetch_queue #(
      .DEPTH(IQ_DEPTH)
   ) u_queue (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .flush      (flush),
      .push       (push),
      .push_data  (push_data),
      .pop        (pop),
      .head       (head),
      .head_valid (iq_valid),
      .count      (count)
   );

   assign iq_inst       = head.inst;
   assign iq_pc         = head.pc;
   assign iq_pred_taken = head.pred_taken[0];
   assign iq_pred_pc    = head.pred_pc;

endmodule

// File: tb/tb_fetcher.sv
// Randomized bench for fetcher: a cache responder drives the request port, a
// reference model predicts the fetched stream, a monitor checks the queue head.
module tb_fetcher;
   import fetcher_pkg::*;

   localparam int          DEPTH = 8;
   localparam logic [31:0] RPC   = 32'h0;
   localparam int          EW    = 97;

   logic         clk_in = 1'b0;
   logic         rst_in = 1'b1;
   logic         rdy_in = 1'b0;
   logic         rob_clear = 1'b0;
   logic [31:0]  clear_pc = '0;
   logic         need_inst;
   logic [31:0]  inst_addr;
   logic         inst_handle = 1'b0;
   logic         inst_ready = 1'b0;
   logic [31:0]  inst_out = '0;
   logic         iq_valid;
   logic [31:0]  iq_inst;
   logic [31:0]  iq_pc;
   logic         iq_pred_taken;
   logic [31:0]  iq_pred_pc;
   logic         dec_pop = 1'b0;
   fetch_state_e dbg_state;

   fetcher #(.IQ_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
      .clear_pc(clear_pc), .need_inst(need_inst), .inst_addr(inst_addr),
      .inst_handle(inst_handle), .inst_ready(inst_ready), .inst_out(inst_out),
      .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc),
      .iq_pred_taken(iq_pred_taken), .iq_pred_pc(iq_pred_pc),
      .dec_pop(dec_pop), .dbg_state(dbg_state)
   );

   always #5 clk_in = ~clk_in;

   int n_cmp = 0;
   int n_bad = 0;
   logic [EW-1:0] exp_q[$];

   logic [31:0] exp_pc = RPC;
   bit          outstanding = 0;
   int          miss_wait = 0;
   int          p_rdy, p_clr, p_pop, p_handle, p_hit;

   task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Next-PC rule written as plain signed arithmetic on the immediate fields.
   function automatic logic [32:0] model_next(input logic [31:0] inst, input logic [31:0] pc);
      longint imm;
      logic taken;
      imm = 4;
      taken = 1'b0;
`ifdef FETCH_PREDICT_EN
      if (inst[6:0] == 7'h6F) begin
         imm = (inst[31] ? -(64'sd1 <<< 20) : 0) + longint'(inst[19:12]) * 4096
             + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
         taken = 1'b1;
      end else if (inst[6:0] == 7'h63 && inst[31]) begin
         imm = -(64'sd1 <<< 12) + longint'(inst[7]) * 2048
             + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
         taken = 1'b1;
      end
`endif
      return {taken, pc + 32'(imm)};
   endfunction

   function automatic logic [31:0] cache_data(input logic [31:0] addr);
      logic [31:0] r;
      r = $urandom;
      if (addr == 32'h20) return 32'hFF9FF06F;
      case ($urandom_range(0, 3))
         0: return 32'h0000_0013;
         1: return {r[31:7], 7'h6F};
         2: return {r[31:7], 7'h63};
         default: return r;
      endcase
   endfunction

   task automatic do_reset();
      @(negedge clk_in);
      rst_in = 1'b1; rob_clear = 1'b0; dec_pop = 1'b0;
      inst_handle = 1'b0; inst_ready = 1'b0;
      repeat (2) @(negedge clk_in);
      #1;
      chk("rst_need_inst", EW'(need_inst), EW'(1'b0));
      chk("rst_inst_addr", EW'(inst_addr), EW'(RPC));
      chk("rst_iq_valid", EW'(iq_valid), EW'(1'b0));
      chk("rst_iq_fields", EW'({iq_inst, iq_pc, iq_pred_pc, iq_pred_taken}), '0);
      chk("rst_state", EW'(dbg_state), EW'(ST_REQ));
      exp_q.delete();
      exp_pc = RPC;
      outstanding = 0;
      @(negedge clk_in);
      rst_in = 1'b0;
   endtask

   task automatic cycle();
      logic        exp_need, do_push, do_clear;
      logic [32:0] nx;
      logic [31:0] r;
      @(negedge clk_in);
      rdy_in   = ($urandom_range(0, 99) < p_rdy);
      rob_clear = ($urandom_range(0, 99) < ((outstanding && miss_wait == 0) ? 40 : p_clr));
      r        = 32'($urandom_range(0, 31)) * 4;
      clear_pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : r;
      dec_pop  = ($urandom_range(0, 99) < p_pop);
      inst_handle = ($urandom_range(0, 99) < p_handle);
      if (outstanding)
         inst_ready = rdy_in && (miss_wait == 0);
      else
         inst_ready = inst_handle && ($urandom_range(0, 99) < p_hit);
      inst_out = cache_data(inst_addr);
      #1;
      exp_need = rdy_in && !rob_clear && !outstanding && (exp_q.size() < DEPTH);
      chk("need_inst", EW'(need_inst), EW'(exp_need));
      chk("inst_addr", EW'(inst_addr), EW'(exp_pc));
      chk("state", EW'(dbg_state), EW'(outstanding ? ST_WAIT : ST_REQ));
      do_push = 1'b0;
      do_clear = rdy_in && rob_clear;
      if (rdy_in && !rob_clear) begin
         if (!outstanding && exp_need && inst_handle) begin
            if (inst_ready) do_push = 1'b1;
            else begin
               outstanding = 1;
               miss_wait = $urandom_range(1, 6);
            end
         end else if (outstanding && inst_ready) begin
            do_push = 1'b1;
            outstanding = 0;
         end else if (outstanding && miss_wait > 0) begin
            miss_wait--;
         end
      end
      nx = model_next(inst_out, exp_pc);
      @(posedge clk_in);
      #1;
      if (do_clear) begin
         exp_q.delete();
         exp_pc = clear_pc;
         outstanding = 0;
      end else if (do_push) begin
         exp_q.push_back({inst_out, exp_pc, nx[32], nx[31:0]});
         exp_pc = nx[31:0];
      end
   endtask

   // Monitor: the queue head is compared with the oldest expected entry,
   // which is retired whenever the decoder consumes it.
   logic [EW-1:0] front;
   always @(negedge clk_in) begin
      #2;
      if (!rst_in) begin
         chk("iq_valid", EW'(iq_valid), EW'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            front = exp_q[0];
            if (iq_valid)
               chk("iq_entry", {iq_inst, iq_pc, iq_pred_taken, iq_pred_pc}, front);
            if (rdy_in && dec_pop && !rob_clear)
               void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      do_reset();
      // Hit streak with no decoder consumption: queue fills, then one pop.
      p_rdy = 100; p_clr = 0; p_pop = 0; p_handle = 100; p_hit = 100;
      repeat (12) cycle();
      p_pop = 100;
      repeat (1) cycle();
      p_pop = 0;
      repeat (3) cycle();
      p_pop = 60;
      repeat (20) cycle();
      // Miss-heavy traffic with freezes.
      p_rdy = 70; p_clr = 3; p_pop = 50; p_handle = 80; p_hit = 20;
      repeat (400) cycle();
      // Mixed random traffic.
      for (int ph = 0; ph < 4; ph++) begin
         p_rdy = $urandom_range(60, 100); p_clr = $urandom_range(1, 8);
         p_pop = $urandom_range(10, 90); p_handle = $urandom_range(40, 100);
         p_hit = $urandom_range(20, 90);
         repeat (500) cycle();
      end
      // Reset while a miss is outstanding.
      p_hit = 0; p_clr = 0; p_rdy = 100;
      for (int i = 0; i < 50 && !outstanding; i++) cycle();
      chk("miss_outstanding_before_reset", EW'(outstanding), EW'(1'b1));
      do_reset();
      p_hit = 50; p_clr = 4; p_pop = 50; p_rdy = 85;
      repeat (400) cycle();
      @(negedge clk_in);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetcher.md
# fetcher

Instruction fetch stage, directly upstream of the Cache instruction port. Holds the PC and issues one instruction request at a time to the Cache. Handles both the same-cycle hit and the multi-cycle miss handshakes. Buffers returned instructions with their PC and predicted next PC in an in-order queue drained by the decoder, and redirects/flushes on `rob_clear`.

## Interface
- `IQ_DEPTH`, 8, instruction queue entries (power of two, ≥2)
- `RESET_PC`, 32'h0, PC after reset
- `clk_in` in 1: system clock
- `rst_in` in 1: reset; synchronous and active-high
- `rdy_in` in 1: global ready; low freezes all state
- `rob_clear` in 1: pipeline flush/redirect
- `clear_pc` in 32: redirect target, valid with `rob_clear`
- `need_inst` out 1: request to Cache
- `inst_addr` out 32: request address (current PC)
- `inst_handle` in 1: Cache accepted request (combinational, same cycle)
- `inst_ready` in 1: instruction valid on `inst_out`
- `inst_out` in 32: fetched instruction
- `iq_valid` out 1: queue head valid
- `iq_inst` out 32: head instruction
- `iq_pc` out 32: head PC
- `iq_pred_taken` out 1: head predicted taken
- `iq_pred_pc` out 32: head predicted next PC
- `dec_pop` in 1: decoder consumes head this cycle (ignored when `iq_valid`=0)

## Operation
- State machine: `REQ` (may issue) and `WAIT` (miss outstanding; at most one in flight).
- Slot rule: in `REQ`, issue only if `count < IQ_DEPTH`. This reserves the slot for the outstanding return.
- `need_inst = rdy_in && !rob_clear && state==REQ && count<IQ_DEPTH`; `inst_addr = pc` always (stable through `WAIT`).
- `REQ` with `inst_handle && inst_ready`: hit. Push {inst_out, pc, pred}, `pc <= next_pc`, stay `REQ`.
- `REQ` with `inst_handle && !inst_ready`: go to `WAIT`.
- `REQ` with `!inst_handle`: stay, retry next cycle.
- `WAIT` with `inst_ready`: push, `pc <= next_pc`, go to `REQ`. `inst_handle` is ignored in `WAIT`.
- Default `next_pc = pc + 4`, 32-bit wrap-around (32'hFFFFFFFC+4 = 0).
- Queue: circular FIFO, `log2(IQ_DEPTH)`-bit pointers plus `count` of width `log2(IQ_DEPTH)+1`.
  - Simultaneous push and pop: count unchanged.
  - Pop when empty: no-op.
  - Push never occurs when full, guaranteed by the slot rule.
- `rob_clear` (with `rdy_in`) has priority over everything:
  - `pc <= clear_pc`, queue emptied, state `REQ`.
  - Any same-cycle `inst_ready` is discarded.
  - The in-flight miss is abandoned; Cache/MemCtrl kill it.
- Reset mid-`WAIT`: same as clear, but `pc <= RESET_PC`.

## Timing
- Reset values: `need_inst`=0, `inst_addr`=`RESET_PC`, `iq_valid`=0, `iq_inst`/`iq_pc`/`iq_pred_pc`=0, `iq_pred_taken`=0, state `REQ`, count 0.
- Hit: request cycle N; entry visible on `iq_*` at N+1. Sustained one instruction per cycle while hitting and not full.
- Miss: request N, `inst_ready` at N+k. Entry visible at N+k+1; next request issued at N+k+1.
- Queue output is registered head: `iq_*` updates the cycle after a pop.
- First request after `rob_clear` at cycle N is issued at N+1 with `inst_addr=clear_pc`.
- `rdy_in`=0: `need_inst` forced 0, no state, PC or queue change; pops ignored.

## Configuration
- `FETCH_PREDICT_EN` defined: static predictor applied to the instruction on push.
  - JAL (opcode 7'b1101111): `next_pc = pc + sext(J-imm)`, `pred_taken`=1.
  - B-type (7'b1100011) with imm sign bit 1 (backward): `next_pc = pc + sext(B-imm)`, `pred_taken`=1.
  - Anything else: pc+4, `pred_taken`=0.
- Undefined: always pc+4, `iq_pred_taken`=0, no decode logic.

## Structure
- Shared package/`Config.v` defines: opcode constants (`OPC_JAL`, `OPC_BRANCH`), `IQ_DEPTH` default, `RESET_PC` default, and queue entry field widths (inst 32, pc 32, pred 1, pred_pc 32).
- One sub-module: `fetch_queue`, a parameterised FIFO with push/pop/flush, `count`, and registered head outputs. The PC, FSM and predictor live in `fetcher`.

## Test plan
- Hit streak: reset, Cache hits every cycle from 0 → `inst_addr` 0,4,8,…. Queue fills to 8 in 8 cycles with `dec_pop`=0. `need_inst` drops at count 8 and resumes after one pop.
- Miss: `inst_handle`=1, `inst_ready` 5 cycles later with 32'h00000013 → one entry {32'h13, pc 0, pred_pc 4}. `need_inst`=0 during `WAIT`.
- Clear during `WAIT`: `rob_clear`, `clear_pc`=32'h100 coincident with `inst_ready` → entry discarded, queue empty, next `inst_addr`=32'h100.
- Push+pop at count 3 → count stays 3, FIFO order preserved. Pop when empty → no change.
- `rdy_in` low for 4 cycles mid-miss → no state change, `need_inst`=0. Resumes correctly.
- `FETCH_PREDICT_EN`: JAL x0,-8 at pc 32'h20 → `pred_taken`=1, `pred_pc`=32'h18, next `inst_addr`=32'h18. Without macro → `pred_pc`=32'h24.
